// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed response latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [29:0]    word_q;
  logic [31:0]    wdata_q;
  logic [3:0]     mask_q;
  logic           ren_q, wen_q;
  logic           rsp_valid_q, err_q, wr_pend_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept, rsp_fire;
  logic [29:0]    src_word;
  logic [3:0]     src_mask;
  logic           src_ren, src_wen, src_err;
  logic [AW-1:0]  src_idx, wr_idx;
  logic [31:0]    wr_lanes, stored, rd_word;
  logic           unused_addr_bits;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign unused_addr_bits = ^i_req_addr[1:0];
  assign o_req_ready = !i_rst && (state_q == IDLE);
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            rsp_fire = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rsp_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the response is built on the accept edge, straight from the request.
  assign src_word = (LATENCY == 1) ? i_req_addr[31:2] : word_q;
  assign src_mask = (LATENCY == 1) ? i_req_mask : mask_q;
  assign src_ren  = (LATENCY == 1) ? i_req_ren : ren_q;
  assign src_wen  = (LATENCY == 1) ? i_req_wen : wen_q;
  assign src_idx  = src_word[AW-1:0];
  assign src_err  = (src_word >= 30'(DEPTH_WORDS)) || (src_ren == src_wen);

  // A write commits on the edge ending its response cycle; forward it to a read sampled on that edge.
  assign wr_idx   = word_q[AW-1:0];
  assign wr_lanes = lanes(mask_q);
  assign stored   = (wr_pend_q && (wr_idx == src_idx))
                  ? ((mem[src_idx] & ~wr_lanes) | (wdata_q & wr_lanes))
                  : mem[src_idx];
  assign rd_word  = stored & lanes(src_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      wr_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_fire;
      err_q       <= rsp_fire && src_err;
      rdata_q     <= (rsp_fire && src_ren && !src_err) ? rd_word : '0;
      wr_pend_q   <= rsp_fire && src_wen && !src_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      word_q  <= i_req_addr[31:2];
      wdata_q <= i_req_wdata;
      mask_q  <= i_req_mask;
      ren_q   <= i_req_ren;
      wen_q   <= i_req_wen;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_pend_q && !i_rst) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_lanes) | (wdata_q & wr_lanes);
    end
  end

  assign o_rsp_valid = rsp_valid_q && !i_rst;
  assign o_rsp_err   = err_q && !i_rst;
  assign o_rsp_rdata = i_rst ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, a_ready, a_ren, a_wen, a_rv, a_err;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic [3:0]  a_mask;
  logic        b_valid, b_ready, b_ren, b_wen, b_rv, b_err;
  logic [31:0] b_addr, b_wdata, b_rd;
  logic [3:0]  b_mask;

  int n_vec = 0;
  int n_err = 0;

  bit [31:0] mem_a [int];
  bit [31:0] mem_b [int];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(a_valid), .o_req_ready(a_ready),
    .i_req_addr(a_addr), .i_req_ren(a_ren), .i_req_wen(a_wen), .i_req_wdata(a_wdata),
    .i_req_mask(a_mask), .o_rsp_valid(a_rv), .o_rsp_rdata(a_rd), .o_rsp_err(a_err));

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b_valid), .o_req_ready(b_ready),
    .i_req_addr(b_addr), .i_req_ren(b_ren), .i_req_wen(b_wen), .i_req_wdata(b_wdata),
    .i_req_mask(b_mask), .o_rsp_valid(b_rv), .o_rsp_rdata(b_rd), .o_rsp_err(b_err));

  task automatic drive(input int sel, input bit v, input logic [31:0] a, input bit r, input bit w,
                       input logic [31:0] d, input logic [3:0] m);
    if (sel == 0) begin
      a_valid = v; a_addr = a; a_ren = r; a_wen = w; a_wdata = d; a_mask = m;
    end else begin
      b_valid = v; b_addr = a; b_ren = r; b_wen = w; b_wdata = d; b_mask = m;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic rv(input int sel);
    return (sel == 0) ? a_rv : b_rv;
  endfunction
  function automatic logic er(input int sel);
    return (sel == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel == 0) ? a_rd : b_rd;
  endfunction

  // Reference: sequential word memory, requests applied in accept order.
  function automatic void model(input int sel, input logic [31:0] a, input bit r, input bit w,
                                input logic [31:0] d, input logic [3:0] m,
                                output bit e, output logic [31:0] data);
    int depth = (sel == 0) ? 1024 : 16;
    longint idx = longint'(a) / 4;
    bit [31:0] ln = 0;
    bit [31:0] cur;
    for (int i = 0; i < 4; i++) if (m[i]) ln |= 32'hFF << (8 * i);
    e = (idx >= depth) || (r == w);
    data = 32'h0;
    if (!e) begin
      cur = (sel == 0) ? mem_a[int'(idx)] : mem_b[int'(idx)];
      if (w) begin
        cur = (cur & ~ln) | (d & ln);
        if (sel == 0) mem_a[int'(idx)] = cur; else mem_b[int'(idx)] = cur;
      end else begin
        data = cur & ln;
      end
    end
  endfunction

  // Starts at a negedge; ends at the negedge of the response cycle.
  task automatic txn(input int sel, input logic [31:0] a, input bit r, input bit w,
                     input logic [31:0] d, input logic [3:0] m, input string tag);
    int lat = (sel == 0) ? 2 : 1;
    int guard = 0;
    bit e;
    logic [31:0] exp_rd;
    while (rdy(sel) !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (rdy(sel) !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_wait: ready=%b required 1", tag, rdy(sel));
    end
    model(sel, a, r, w, d, m, e, exp_rd);
    drive(sel, 1'b1, a, r, w, d, m);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, a, r, w, d, m);
      if (k < lat) begin
        n_vec++;
        if (rv(sel) !== 1'b0 || rdy(sel) !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy: valid=%b ready=%b required 0 0", tag, rv(sel), rdy(sel));
        end
      end else begin
        n_vec++;
        if (rv(sel) !== 1'b1 || rdy(sel) !== 1'b1) begin
          n_err++;
          $display("FAIL %s rsp_cycle: valid=%b ready=%b required 1 1", tag, rv(sel), rdy(sel));
        end
        n_vec++;
        if (er(sel) !== e) begin
          n_err++;
          $display("FAIL %s err: got %b required %b", tag, er(sel), e);
        end
        n_vec++;
        if (rd(sel) !== exp_rd) begin
          n_err++;
          $display("FAIL %s rdata: got %h required %h", tag, rd(sel), exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a_ready, a_rv, a_err, b_ready, b_rv, b_err} !== 6'b0 || a_rd !== 32'h0 || b_rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: a rdy/v/e=%b%b%b b=%b%b%b rd=%h/%h required all 0",
               a_ready, a_rv, a_err, b_ready, b_rv, b_err, a_rd, b_rd);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b %b required 1 1", a_ready, b_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_rd_wr();
    txn(0, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, "wr_full");
    txn(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, "rd_full");
  endtask

  task automatic test_byte_mask();
    txn(0, 32'h12, 1'b0, 1'b1, 32'h00AB0000, 4'b0100, "wr_byte");
    txn(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, "rd_after_byte");
    txn(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1100, "rd_mask_hi");
    txn(0, 32'h10, 1'b0, 1'b1, 32'h11111111, 4'b0000, "wr_mask0");
    txn(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, "rd_after_mask0");
  endtask

  task automatic test_errors();
    txn(0, 32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF, "err_both");
    txn(0, 32'h10, 1'b0, 1'b0, 32'h55555555, 4'hF, "err_none");
    txn(0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'hF, "err_oor_rd");
    txn(0, 32'h1010, 1'b0, 1'b1, 32'h66666666, 4'hF, "err_oor_wr");
    txn(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, "rd_unchanged");
  endtask

  task automatic test_back_to_back();
    txn(0, 32'h20, 1'b0, 1'b1, 32'h01020304, 4'hF, "b2b_init");
    txn(0, 32'h20, 1'b0, 1'b1, $urandom, 4'b1011, "b2b_wr");
    txn(0, 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, "b2b_rd");
  endtask

  task automatic test_reset_busy();
    txn(0, 32'h30, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, "rb_init");
    drive(0, 1'b1, 32'h30, 1'b0, 1'b1, 32'h12345678, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 32'h30, 1'b0, 1'b1, 32'h12345678, 4'hF);
    rst = 1'b1;
    #1;
    n_vec++;
    if (a_ready !== 1'b0 || a_rv !== 1'b0) begin
      n_err++;
      $display("FAIL rb_in_reset: ready=%b valid=%b required 0 0", a_ready, a_rv);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_ready !== 1'b1 || a_rv !== 1'b0) begin
      n_err++;
      $display("FAIL rb_after_reset: ready=%b valid=%b required 1 0", a_ready, a_rv);
    end
    @(negedge clk);
    n_vec++;
    if (a_rv !== 1'b0) begin
      n_err++;
      $display("FAIL rb_no_rsp: valid=%b required 0", a_rv);
    end
    txn(0, 32'h30, 1'b1, 1'b0, 32'h0, 4'hF, "rb_rd");
  endtask

  task automatic test_hold_valid();
    bit e;
    logic [31:0] exp_rd;
    int cnt = 0;
    model(0, 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, e, exp_rd);
    drive(0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 4'hF);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 6) drive(0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 4'hF);
      if (a_rv === 1'b1) begin
        cnt++;
        n_vec++;
        if (a_rd !== exp_rd || a_err !== 1'b0) begin
          n_err++;
          $display("FAIL hold_rdata: got %h/%b required %h/0", a_rd, a_err, exp_rd);
        end
      end
    end
    n_vec++;
    if (cnt != 3) begin
      n_err++;
      $display("FAIL hold_count: got %0d responses required 3", cnt);
    end
  endtask

  task automatic test_stream_l1();
    logic [31:0] sa [4];
    bit          sw [4];
    logic [31:0] sd [4];
    logic [3:0]  sm [4];
    bit          se [4];
    logic [31:0] sr [4];
    txn(1, 32'h0, 1'b0, 1'b1, $urandom, 4'hF, "s_init0");
    txn(1, 32'h4, 1'b0, 1'b1, $urandom, 4'hF, "s_init1");
    txn(1, 32'h8, 1'b0, 1'b1, $urandom, 4'hF, "s_init2");
    sa[0] = 32'h8; sw[0] = 1'b1; sd[0] = $urandom; sm[0] = 4'b0011;
    sa[1] = 32'h8; sw[1] = 1'b0; sd[1] = 32'h0;    sm[1] = 4'hF;
    sa[2] = 32'h0; sw[2] = 1'b0; sd[2] = 32'h0;    sm[2] = 4'hF;
    sa[3] = 32'h4; sw[3] = 1'b0; sd[3] = 32'h0;    sm[3] = 4'b1010;
    for (int i = 0; i < 4; i++) model(1, sa[i], !sw[i], sw[i], sd[i], sm[i], se[i], sr[i]);
    drive(1, 1'b1, sa[0], !sw[0], sw[0], sd[0], sm[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive(1, 1'b1, sa[i+1], !sw[i+1], sw[i+1], sd[i+1], sm[i+1]);
      else drive(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      n_vec++;
      if (b_rv !== 1'b1 || b_err !== se[i] || b_rd !== sr[i]) begin
        n_err++;
        $display("FAIL stream_%0d: valid/err/rdata=%b/%b/%h required 1/%b/%h", i, b_rv, b_err, b_rd, se[i], sr[i]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (b_rv !== 1'b0) begin
      n_err++;
      $display("FAIL stream_tail: valid=%b required 0", b_rv);
    end
  endtask

  task automatic test_random(input int sel);
    int depth = (sel == 0) ? 1024 : 16;
    logic [31:0] base = (sel == 0) ? 32'h40 : 32'h20;
    logic [31:0] a;
    int kind;
    for (int k = 0; k < 8; k++) txn(sel, base + 4 * k, 1'b0, 1'b1, $urandom, 4'hF, "rnd_init");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 8) a = base + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      else if (kind == 8) a = depth * 4 + 4 * $urandom_range(0, 63);
      else a = 32'h8000_0000 | base;
      kind = $urandom_range(0, 7);
      txn(sel, a, (kind < 3) || (kind == 6), (kind >= 3 && kind <= 6), $urandom,
          4'($urandom_range(0, 15)), "rnd");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rd_wr();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_busy();
    test_hold_valid();
    test_stream_l1();
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1, the single clock; every state change happens on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_req_valid, input, 1, requester presents a request.
REQ-006 SHALL have port o_req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port i_req_addr, input, 32, byte address; bits [1:0] ignored.
REQ-008 SHALL have port i_req_ren, input, 1, read request.
REQ-009 SHALL have port i_req_wen, input, 1, write request.
REQ-010 SHALL have port i_req_wdata, input, 32, write data, already placed in its byte lanes.
REQ-011 SHALL have port i_req_mask, input, 4, byte-lane enables; bit n covers bits [8n+7:8n].
REQ-012 SHALL have port o_rsp_valid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port o_rsp_rdata, output, 32, read data, valid only while o_rsp_valid is high.
REQ-014 SHALL have port o_rsp_err, output, 1, request was illegal, valid only while o_rsp_valid is high.

Function
REQ-015 Accept SHALL occur in cycle T when i_req_valid and o_req_ready are both high; all request fields SHALL be registered at that accept.
REQ-016 At most one request SHALL be outstanding; FSM states: IDLE (ready=1), BUSY (ready=0).
REQ-017 IDLE->BUSY on accept; BUSY SHALL count LATENCY cycles; o_rsp_valid SHALL be high exactly in cycle T+LATENCY, for exactly one cycle.
REQ-018 o_req_ready SHALL be high in the response cycle; a new accept in that cycle SHALL be legal (throughput one request per LATENCY cycles).
REQ-019 With LATENCY=1, back-to-back accepts in consecutive cycles SHALL be supported, with one response per cycle.
REQ-020 Word index SHALL be i_req_addr[31:2]; an index >= DEPTH_WORDS SHALL be out of range.
REQ-021 err SHALL be 1 for: out-of-range address; ren and wen both high; ren and wen both low. An err request SHALL not modify memory and SHALL return rdata=0.
REQ-022 A legal write SHALL update only the masked bytes, on the rising edge that ends the response cycle; unmasked bytes SHALL remain unchanged; mask 0000 SHALL be a legal no-op with err=0.
REQ-023 A legal read SHALL return the stored word with unmasked byte lanes forced to 0.
REQ-024 A read accepted in the response cycle of a write to the same word SHALL return the post-write data.
REQ-025 Outputs SHALL be driven from registers or the FSM state only; no combinational path SHALL run from request inputs to outputs.
REQ-026 i_req_valid while o_req_ready is low SHALL be ignored, with no internal effect.

Reset
REQ-027 While i_rst is high: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, and the FSM SHALL be in IDLE.
REQ-028 In the first cycle after i_rst falls, o_req_ready SHALL be 1.
REQ-029 Reset while BUSY SHALL drop the in-flight request: no response, and no memory write.
REQ-030 Memory contents SHALL not be cleared by reset.

Verification
REQ-031 With LATENCY=2: write 0xDEADBEEF to 0x10 with mask 1111 accepted at T -> rsp_valid at T+2 with err=0. Then read 0x10 with mask 1111 -> rdata 0xDEADBEEF.
REQ-032 Byte write 0x00AB0000 to 0x12 with mask 0100 over 0xDEADBEEF, then full read -> 0xDEABBEEF. Read with mask 1100 -> 0xDEAB0000.
REQ-033 Request with ren=wen=1, then request to 0x1000 (index 1024) -> err=1 and rdata=0; a later read shows memory unchanged.
REQ-034 Write to 0x20 accepted in the response cycle of the previous request, followed immediately by a read of 0x20 -> ready pattern 1,0,1, with post-write data returned.
REQ-035 Write 0x12345678 to 0x30 accepted, i_rst asserted at T+1 -> no rsp_valid; after reset, a read of 0x30 returns the prior contents.
REQ-036 i_req_valid held high while busy -> exactly one response per accept; LATENCY=1 streaming of 4 reads -> 4 consecutive rsp_valid cycles.
